// File: rtl/memory_dumper.sv
// Post-halt RAM readback: walks DUMP_WORDS words from START_ADDR and streams them on valid/ready.
// Optional DUMPER_CHECKSUM_EN appends one beat carrying the running sum of the dumped words.
module memory_dumper #(
    parameter int unsigned ADDR_WIDTH = 5,
    parameter int unsigned DATA_WIDTH = 16,
    parameter int unsigned START_ADDR = 0,
    parameter int unsigned DUMP_WORDS = 32
) (
    input  logic                  clock,
    input  logic                  reset_n,
    input  logic                  start_dump,
    output logic                  mem_req,
    output logic [ADDR_WIDTH-1:0] mem_addr,
    input  logic [DATA_WIDTH-1:0] mem_read_data,
    output logic                  out_valid,
    input  logic                  out_ready,
    output logic [ADDR_WIDTH-1:0] out_addr,
    output logic [DATA_WIDTH-1:0] out_data,
    output logic                  out_last,
    output logic                  dump_busy,
    output logic                  dump_complete
);

    localparam int unsigned CntWidth = (DUMP_WORDS > 1) ? $clog2(DUMP_WORDS) : 1;
    localparam logic [CntWidth-1:0]   LastCnt   = CntWidth'(DUMP_WORDS - 1);
    localparam logic [ADDR_WIDTH-1:0] StartAddr = ADDR_WIDTH'(START_ADDR);

`ifdef DUMPER_CHECKSUM_EN
    typedef enum logic [2:0] {StIdle, StAddr, StWait, StHold, StDone, StCsum} state_e;
`else
    typedef enum logic [2:0] {StIdle, StAddr, StWait, StHold, StDone} state_e;
`endif

    state_e                  state_q;
    logic [CntWidth-1:0]     cnt_q;
    logic [ADDR_WIDTH-1:0]   addr_q;
    logic                    mem_req_q;
    logic                    out_valid_q;
    logic [ADDR_WIDTH-1:0]   out_addr_q;
    logic [DATA_WIDTH-1:0]   out_data_q;
    logic                    out_last_q;
    logic                    busy_q;
    logic                    complete_q;
`ifdef DUMPER_CHECKSUM_EN
    logic [DATA_WIDTH-1:0]   sum_q;
`endif

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state_q     <= StIdle;
            cnt_q       <= '0;
            addr_q      <= '0;
            mem_req_q   <= 1'b0;
            out_valid_q <= 1'b0;
            out_addr_q  <= '0;
            out_data_q  <= '0;
            out_last_q  <= 1'b0;
            busy_q      <= 1'b0;
            complete_q  <= 1'b0;
`ifdef DUMPER_CHECKSUM_EN
            sum_q       <= '0;
`endif
        end else begin
            unique case (state_q)
                StIdle, StDone: begin
                    if (start_dump) begin
                        state_q    <= StAddr;
                        cnt_q      <= '0;
                        addr_q     <= StartAddr;
                        mem_req_q  <= 1'b1;
                        busy_q     <= 1'b1;
                        complete_q <= 1'b0;
`ifdef DUMPER_CHECKSUM_EN
                        sum_q      <= '0;
`endif
                    end
                end
                StAddr: begin
                    state_q <= StWait;
                end
                // Registered RAM: data for addr_q is on mem_read_data this cycle.
                StWait: begin
                    out_data_q  <= mem_read_data;
                    out_addr_q  <= addr_q;
                    out_valid_q <= 1'b1;
`ifdef DUMPER_CHECKSUM_EN
                    out_last_q  <= 1'b0;
                    sum_q       <= sum_q + mem_read_data;
`else
                    out_last_q  <= (cnt_q == LastCnt);
`endif
                    state_q     <= StHold;
                end
                StHold: begin
                    if (out_ready) begin
                        if (cnt_q == LastCnt) begin
`ifdef DUMPER_CHECKSUM_EN
                            // Checksum beat follows back-to-back; valid stays high.
                            state_q    <= StCsum;
                            mem_req_q  <= 1'b0;
                            out_data_q <= sum_q;
                            out_addr_q <= addr_q + 1'b1;
                            out_last_q <= 1'b1;
`else
                            state_q     <= StDone;
                            out_valid_q <= 1'b0;
                            out_last_q  <= 1'b0;
                            mem_req_q   <= 1'b0;
                            busy_q      <= 1'b0;
                            complete_q  <= 1'b1;
`endif
                        end else begin
                            state_q     <= StAddr;
                            out_valid_q <= 1'b0;
                            cnt_q       <= cnt_q + 1'b1;
                            addr_q      <= addr_q + 1'b1;
                        end
                    end
                end
`ifdef DUMPER_CHECKSUM_EN
                StCsum: begin
                    if (out_ready) begin
                        state_q     <= StDone;
                        out_valid_q <= 1'b0;
                        out_last_q  <= 1'b0;
                        busy_q      <= 1'b0;
                        complete_q  <= 1'b1;
                    end
                end
`endif
                default: begin
                    state_q <= StIdle;
                end
            endcase
        end
    end

    assign mem_req       = mem_req_q;
    assign mem_addr      = addr_q;
    assign out_valid     = out_valid_q;
    assign out_addr      = out_addr_q;
    assign out_data      = out_data_q;
    assign out_last      = out_last_q;
    assign dump_busy     = busy_q;
    assign dump_complete = complete_q;

endmodule
